// File: rtl/sfp_pkg.sv
// Shared definitions for the sfp lane sequencer: default widths and FSM state encoding.
package sfp_pkg;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int LEN_BW  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ACC  = 3'd2,
    RELU = 3'd3,
    CAPT = 3'd4,
    OUT  = 3'd5
  } state_e;

endpackage

// File: rtl/sfp_seq.sv
// Sequencer for one sfp lane: clear, cfg_len accumulate beats, a relu beat,
// then capture the psum and present it on a valid/ready output.
module sfp_seq
  import sfp_pkg::*;
#(
  parameter int bw      = BW,
  parameter int psum_bw = PSUM_BW,
  parameter int len_bw  = LEN_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  cfg_len,
  input  logic               cfg_relu,
  output logic               busy,
  input  logic [bw-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               sfp_clr,
  output logic               sfp_acc,
  output logic               sfp_relu,
  output logic [bw-1:0]      sfp_in,
  input  logic [psum_bw-1:0] sfp_out,
  output logic [psum_bw-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  state_e              state_r, state_s;
  logic [len_bw-1:0]   count_r, count_s;
  logic [len_bw-1:0]   len_r, len_s;
  logic [len_bw-1:0]   count_inc_s;
  logic                relu_r, relu_s;
  logic [psum_bw-1:0]  out_data_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                in_ready_r;
  logic                sfp_clr_r;
  logic                sfp_relu_r;

  // Next-state, beat counter and configuration latch.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    len_s       = len_r;
    relu_s      = relu_r;
    count_inc_s = count_r + {{(len_bw-1){1'b0}}, 1'b1};
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CLR;
          len_s   = cfg_len;
          relu_s  = cfg_relu;
          count_s = {len_bw{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      CLR: begin
        if (len_r != {len_bw{1'b0}}) begin
          state_s = ACC;
        end else begin
          state_s = RELU;
        end
      end
      ACC: begin
        // Compare-equal on the incremented count, so len = all-ones never wraps.
        if (in_valid) begin
          count_s = count_inc_s;
          if (count_inc_s == len_r) begin
            state_s = RELU;
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      RELU:    state_s = CAPT;
      CAPT:    state_s = OUT;
      OUT: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, configuration and registered control outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      count_r     <= {len_bw{1'b0}};
      len_r       <= {len_bw{1'b0}};
      relu_r      <= 1'b0;
      out_data_r  <= {psum_bw{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      sfp_clr_r   <= 1'b0;
      sfp_relu_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      len_r       <= len_s;
      relu_r      <= relu_s;
      out_data_r  <= (state_r == CAPT) ? sfp_out : out_data_r;
      out_valid_r <= (state_s == OUT);
      busy_r      <= (state_s != IDLE);
      in_ready_r  <= (state_s == ACC);
      sfp_clr_r   <= (state_s == CLR);
      sfp_relu_r  <= (state_s == RELU) && relu_s;
    end
  end

  assign busy      = busy_r;
  assign in_ready  = in_ready_r;
  assign sfp_clr   = sfp_clr_r;
  assign sfp_acc   = in_ready_r && in_valid;
  assign sfp_relu  = sfp_relu_r;
  assign sfp_in    = in_data;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sfp_seq.sv
// Integration bench: sfp_seq driving a behavioural sfp lane, with a scoreboard
// of expected results computed from the operand lists.
module tb_sfp_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_len = 8'd0;
  logic        cfg_relu = 1'b0;
  logic        busy;
  logic [3:0]  in_data = 4'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sfp_clr, sfp_acc, sfp_relu;
  logic [3:0]  sfp_in;
  logic [15:0] sfp_out;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic signed [15:0] psum;
  logic signed [15:0] thres = 16'sd0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  int          ops_q[$];

  sfp_seq dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
    .busy(busy), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sfp_clr(sfp_clr), .sfp_acc(sfp_acc), .sfp_relu(sfp_relu), .sfp_in(sfp_in),
    .sfp_out(sfp_out), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural sfp lane: clear, signed accumulate, relu against thres.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      psum <= 16'sd0;
    else if (sfp_clr)
      psum <= 16'sd0;
    else if (sfp_acc)
      psum <= psum + {{12{sfp_in[3]}}, sfp_in};
    else if (sfp_relu)
      psum <= (psum > thres) ? psum : 16'sd0;
    else
      psum <= psum;
  end
  assign sfp_out = psum;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // One full sequence from IDLE; operands come from ops_q. Returns at a negedge in IDLE.
  task automatic run_seq(input int len, input bit relu, input int stall_at, input int stall_n,
                         input int hold, input bit start_on_hs);
    int sum = 0;
    int beat = 0;
    int guard = 0;
    int stall_left = stall_n;
    logic [15:0] e;
    foreach (ops_q[i]) sum += ops_q[i];
    if (relu && sum < 0) sum = 0;
    exp_q.push_back(16'(sum));

    start = 1'b1; cfg_len = 8'(len); cfg_relu = relu;
    @(negedge clk);
    start = 1'b0; cfg_len = 8'd0; cfg_relu = 1'b0;
    check_eq("clr_busy", busy, 1);
    check_eq("clr_pulse", sfp_clr, 1);
    check_eq("clr_in_ready", in_ready, 0);
    @(negedge clk);
    check_eq("clr_one_cycle", sfp_clr, 0);
    while (beat < len && guard < 2000) begin
      check_eq("acc_in_ready", in_ready, 1);
      if (beat == stall_at && stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end else begin
        in_valid = 1'b1;
        in_data = 4'(ops_q[beat]);
        beat++;
      end
      #1;
      check_eq("acc_follows_valid", sfp_acc, in_valid);
      check_eq("sfp_in_pass", sfp_in, in_data);
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check_eq("acc_timeout", 1, 0);
    in_valid = 1'b0;
    #1;
    check_eq("relu_in_ready", in_ready, 0);
    check_eq("relu_ctrl", sfp_relu, relu);
    check_eq("relu_no_acc", sfp_acc, 0);
    @(negedge clk);
    check_eq("capt_out_valid", out_valid, 0);
    check_eq("capt_relu_off", sfp_relu, 0);
    @(negedge clk);
    check_eq("out_valid", out_valid, 1);
    check_eq("out_busy", busy, 1);
    e = exp_q.pop_front();
    check_eq("out_data", out_data, e);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_data", out_data, e);
      check_eq("hold_busy", busy, 1);
      check_eq("hold_no_clr", sfp_clr, 0);
    end
    start = start_on_hs;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check_eq("hs_valid_low", out_valid, 0);
    check_eq("hs_idle_busy", busy, 0);
    @(negedge clk);
    check_eq("idle_stays", busy, 0);
    check_eq("idle_no_clr", sfp_clr, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_clr", sfp_clr, 0);
    reset = 1'b1;
    @(negedge clk);

    ops_q = '{3, -2, 5};     run_seq(3, 1'b1, 99, 0, 0, 1'b0);
    ops_q = '{-4, -4, 1};    run_seq(3, 1'b1, 99, 0, 0, 1'b0);
    ops_q = '{-4, -4, 1};    run_seq(3, 1'b0, 99, 0, 0, 1'b0);
    ops_q = '{1, 1, 1, 1};   run_seq(4, 1'b1, 2, 2, 0, 1'b0);
    ops_q = '{2, 3};         run_seq(2, 1'b0, 99, 0, 5, 1'b1);
    ops_q.delete();          run_seq(0, 1'b0, 99, 0, 0, 1'b0);
    ops_q = '{6};            run_seq(1, 1'b1, 99, 0, 0, 1'b0);

    // Abort in ACC after two beats.
    start = 1'b1; cfg_len = 8'd4; cfg_relu = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'd3;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_in_acc", in_ready, 1);
    reset = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_acc", sfp_acc, 0);
    check_eq("abort_clr", sfp_clr, 0);
    check_eq("abort_relu", sfp_relu, 0);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_out_data", out_data, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ops_q = '{7, 7};         run_seq(2, 1'b0, 99, 0, 0, 1'b0);

    ops_q.delete();
    for (int i = 0; i < 255; i++) ops_q.push_back(int'($urandom_range(0, 15)) - 8);
    run_seq(255, 1'b0, 100, 3, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
